ka_step_scheduler: RTL and testbench

- Sequences one Karatsuba step of an N-bit GF(2) polynomial multiply using a single shared half-width multiplier.
- Takes operands A and B, splits each into low and high halves of HALF bits, and issues three sub-products in order: lo = AL*BL, hi = AH*BH, mid = (AL^AH)*(BL^BH).
- Combines the sub-products into the (2N-1)-bit carry-less product: lo ^ ((mid^lo^hi) << HALF) ^ (hi << 2*HALF).
- Sits between the operand source and the overlap/recombination stages of the KA tree. The sub-multiplier is external and has variable latency.

---
 rtl/ka_step_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_ka_step_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ka_step_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ka_step_scheduler
//
// Purpose:
//   Sequences one Karatsuba step of an N-bit carry-less (GF(2)) polynomial
//   multiply. A single external half-width multiplier is shared: the three
//   sub-products lo = AL*BL, hi = AH*BH and mid = (AL^AH)*(BL^BH) are issued
//   one after another. They are then recombined into the (2N-1)-bit product
//     prod = lo ^ ((mid ^ lo ^ hi) << HALF) ^ (hi << 2*HALF).
//   The sub-multiplier has variable latency. The scheduler waits on its
//   mul_done pulse with no timeout.
//
// Handshakes:
//   Both interfaces use strict valid/ready. A transfer happens on a rising
//   clock edge where valid and ready are both high. A producer holds valid
//   and its data stable until that edge. in_ready is high only in IDLE.
//   out_valid is high only in OUT. mul_start/mul_done are one-cycle pulses,
//   not a valid/ready pair. mul_a/mul_b stay constant from the start pulse
//   until the matching mul_done.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand pair handshake; a_in, b_in are the operands
//                        (bit i = coefficient of x^i)
//   mul_start            one-cycle launch pulse to the sub-multiplier
//   mul_a, mul_b         HALF-bit sub-operands, held until mul_done
//   mul_done, mul_p      one-cycle completion pulse and (2*HALF-1)-bit product
//   out_valid/out_ready  product handshake; prod_out is the (2N-1)-bit result
//   busy                 high in every state except IDLE
//   op_count             completed output handshakes, wraps to zero
//   dbg_state_o          current FSM state encoding, for observation only
//
// HALF is derived from N inside the module, so it cannot be overridden.
// ---------------------------------------------------------------------------
module ka_step_scheduler #(
    parameter int N     = 10,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       a_in,
    input  logic [N-1:0]       b_in,
    output logic               mul_start,
    output logic [N/2-1:0]     mul_a,
    output logic [N/2-1:0]     mul_b,
    input  logic               mul_done,
    input  logic [N-2:0]       mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-2:0]     prod_out,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count,
    output logic [3:0]         dbg_state_o
);

    localparam int HALF = N / 2;
    localparam int PW   = 2 * HALF - 1;   // sub-product width
    localparam int OW   = 2 * N - 1;      // full product width

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LO_ISS   = 4'd1,
        S_LO_WAIT  = 4'd2,
        S_HI_ISS   = 4'd3,
        S_HI_WAIT  = 4'd4,
        S_MID_ISS  = 4'd5,
        S_MID_WAIT = 4'd6,
        S_COMB     = 4'd7,
        S_OUT      = 4'd8
    } state_e;

    state_e             state_q;

    // Captured operands and sub-products
    logic [N-1:0]       a_q;
    logic [N-1:0]       b_q;
    logic [PW-1:0]      lo_q;
    logic [PW-1:0]      hi_q;
    logic [PW-1:0]      mid_q;

    // Registered outputs
    logic               in_ready_q;
    logic               busy_q;
    logic               mul_start_q;
    logic [HALF-1:0]    mul_a_q;
    logic [HALF-1:0]    mul_b_q;
    logic               out_valid_q;
    logic [OW-1:0]      prod_q;
    logic [CNT_W-1:0]   count_q;

    // Next-value terms computed combinationally
    logic [PW-1:0]      mid_fix_d;
    logic [OW-1:0]      prod_d;
    logic [CNT_W-1:0]   count_d;

    // Operand halves of the captured pair
    logic [HALF-1:0]    al;
    logic [HALF-1:0]    ah;
    logic [HALF-1:0]    bl;
    logic [HALF-1:0]    bh;

    assign al = a_q[HALF-1:0];
    assign ah = a_q[N-1:HALF];
    assign bl = b_q[HALF-1:0];
    assign bh = b_q[N-1:HALF];

    // Karatsuba recombination. The middle term (mid ^ lo ^ hi) is AL*BH ^ AH*BL.
    // Each term is zero-extended to OW bits before shifting. The top bits
    // therefore fall off only where the true product has no coefficients.
    always_comb begin
        mid_fix_d = mid_q ^ lo_q ^ hi_q;
        prod_d    = {{(OW-PW){1'b0}}, lo_q}
                  ^ ({{(OW-PW){1'b0}}, mid_fix_d} << HALF)
                  ^ ({{(OW-PW){1'b0}}, hi_q} << (2 * HALF));
        count_d   = count_q + CNT_W'(1);
    end

    // Single FSM block. Each registered output is set together with the
    // state transition that enters the state where it must hold. Every
    // output is then already correct in the first cycle of that state.
    // mul_done is looked at only in the *_WAIT arms. A pulse in any other
    // state, including the ISS cycle of its own launch, is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            mid_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_valid_q <= 1'b0;
            prod_q      <= '0;
            count_q     <= '0;
        end else begin
            // The launch pulse lasts exactly one cycle unless re-armed below
            mul_start_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q         <= a_in;
                        b_q         <= b_in;
                        mul_a_q     <= a_in[HALF-1:0];
                        mul_b_q     <= b_in[HALF-1:0];
                        mul_start_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_LO_ISS;
                    end
                end

                S_LO_ISS: state_q <= S_LO_WAIT;

                S_LO_WAIT: begin
                    if (mul_done) begin
                        lo_q        <= mul_p;
                        mul_a_q     <= ah;
                        mul_b_q     <= bh;
                        mul_start_q <= 1'b1;
                        state_q     <= S_HI_ISS;
                    end
                end

                S_HI_ISS: state_q <= S_HI_WAIT;

                S_HI_WAIT: begin
                    if (mul_done) begin
                        hi_q        <= mul_p;
                        mul_a_q     <= al ^ ah;
                        mul_b_q     <= bl ^ bh;
                        mul_start_q <= 1'b1;
                        state_q     <= S_MID_ISS;
                    end
                end

                S_MID_ISS: state_q <= S_MID_WAIT;

                S_MID_WAIT: begin
                    if (mul_done) begin
                        mid_q   <= mul_p;
                        state_q <= S_COMB;
                    end
                end

                S_COMB: begin
                    prod_q      <= prod_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end

                S_OUT: begin
                    // prod_q is left alone here. The result therefore stays
                    // stable under back-pressure and persists into IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        count_q     <= count_d;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign mul_start   = mul_start_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign out_valid   = out_valid_q;
    assign prod_out    = prod_q;
    assign op_count    = count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ka_step_scheduler.sv
`timescale 1ns/1ps
module tb_ka_step_scheduler;

  localparam int N     = 10;
  localparam int HALF  = N / 2;
  localparam int CNT_W = 16;
  localparam int PW    = 2 * HALF - 1;
  localparam int OW    = 2 * N - 1;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_HI_WAIT = 4'd4;
  localparam logic [3:0] ST_OUT     = 4'd8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a_in;
  logic [N-1:0]     b_in;
  logic             mul_start;
  logic [HALF-1:0]  mul_a;
  logic [HALF-1:0]  mul_b;
  logic             mul_done;
  logic [PW-1:0]    mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [OW-1:0]    prod_out;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [3:0]       dbg_state_o;

  int checks = 0;
  int errors = 0;

  // Sub-multiplier model controls
  int              mul_lat      = 1;
  bit              stray_req    = 1'b0;
  bit              stray_on_iss = 1'b0;
  bit              hold_chk     = 1'b1;
  int              starts       = 0;
  int              m_cnt        = 0;
  logic [HALF-1:0] m_a;
  logic [HALF-1:0] m_b;
  logic [2*HALF-1:0] issue_q[$];

  // Scoreboard
  logic [OW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_count = '0;

  ka_step_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_p      (mul_p),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .prod_out   (prod_out),
    .busy       (busy),
    .op_count   (op_count),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference models ----------------
  function automatic logic [OW-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (b[i]) r = r ^ ({{(N-1){1'b0}}, a} << i);
    return r;
  endfunction

  function automatic logic [PW-1:0] half_mul(input logic [HALF-1:0] a, input logic [HALF-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < HALF; i++)
      if (b[i]) r = r ^ ({{(HALF-1){1'b0}}, a} << i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- sub-multiplier model + per-cycle monitor ----------------
  initial begin
    mul_done = 1'b0;
    mul_p    = '0;
    forever begin
      @(posedge clk); #1;
      mul_done = 1'b0;
      mul_p    = '0;
      if (rst_n) check("ready_vs_busy", in_ready, !busy);
      if (m_cnt > 0) begin
        if (hold_chk) begin
          check("mul_a_hold", mul_a, m_a);
          check("mul_b_hold", mul_b, m_b);
        end
        m_cnt--;
        if (m_cnt == 0) begin
          mul_done = 1'b1;
          mul_p    = half_mul(m_a, m_b);
        end
      end
      if (stray_req) begin
        mul_done  = 1'b1;
        mul_p     = '1;
        stray_req = 1'b0;
      end
      if (mul_start) begin
        starts++;
        issue_q.push_back({mul_a, mul_b});
        m_a   = mul_a;
        m_b   = mul_b;
        m_cnt = mul_lat;
        if (stray_on_iss) begin
          mul_done = 1'b1;
          mul_p    = '1;
        end
      end
    end
  end

  // ---------------- driver: one full operation ----------------
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [OW-1:0] prod_exp,
                        input int lat_mul, input bit rnd_ready, input int hold, input bit stray_out);
    int guard;
    int lat;
    int hold_left;
    bit hs;
    logic [OW-1:0] exp_v;
    mul_lat = lat_mul;
    starts  = 0;
    issue_q.delete();
    guard = 0;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    check("in_ready_wait", in_ready, 1'b1);
    exp_q.push_back(prod_exp);
    in_valid = 1'b1; a_in = a; b_in = b;
    @(posedge clk); #1;
    // Keep offering other operands while busy; they must not be taken
    a_in = N'($urandom_range(0, (1 << N) - 1));
    b_in = N'($urandom_range(0, (1 << N) - 1));
    check("in_ready_busy", in_ready, 1'b0);
    lat = 1; guard = 0;
    while (!out_valid && guard < 500) begin @(posedge clk); #1; lat++; guard++; end
    check("latency", lat, 3 * (1 + lat_mul) + 2);
    exp_v = exp_q.pop_front();
    hold_left = hold; hs = 1'b0; guard = 0;
    if (stray_out) stray_req = 1'b1;
    while (!hs && guard < 1000) begin
      check("out_valid", out_valid, 1'b1);
      check("prod_out", prod_out, exp_v);
      check("in_ready_out", in_ready, 1'b0);
      check("state_out", dbg_state_o, ST_OUT);
      if (hold_left > 0) begin
        check("op_count_held", op_count, exp_count);
        out_ready = 1'b0;
        hold_left--;
      end else if (rnd_ready) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      if (out_ready) in_valid = 1'b0;
      @(posedge clk); #1;
      guard++;
      if (out_ready) hs = 1'b1;
    end
    check("handshake", hs, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (hs) exp_count++;
    check("out_valid_drop", out_valid, 1'b0);
    check("idle_after", dbg_state_o, ST_IDLE);
    check("op_count", op_count, exp_count);
    check("starts_per_op", starts, 3);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mul_start", mul_start, 1'b0);
    check("rst_mul_a", mul_a, '0);
    check("rst_mul_b", mul_b, '0);
    check("rst_prod", prod_out, '0);
    check("rst_op_count", op_count, '0);
    check("rst_state", dbg_state_o, ST_IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // (x^5+1)^2 = x^10+1, minimum latency of 8
    run_op(10'h021, 10'h021, 19'h00401, 1, 1'b0, 0, 1'b0);

    // All-ones times one: check issue order and operands
    run_op(10'h3FF, 10'h001, 19'h003FF, 1, 1'b0, 0, 1'b0);
    check("issue_count", issue_q.size(), 3);
    if (issue_q.size() == 3) begin
      check("issue_lo", issue_q[0], {5'h1F, 5'h01});
      check("issue_hi", issue_q[1], {5'h1F, 5'h00});
      check("issue_mid", issue_q[2], {5'h00, 5'h01});
    end

    // Stray mul_done while idle
    stray_req = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stray_idle_state", dbg_state_o, ST_IDLE);
      check("stray_idle_start", mul_start, 1'b0);
      check("stray_idle_out_valid", out_valid, 1'b0);
    end
    check("stray_idle_count", op_count, exp_count);

    // Strays in every ISS cycle and in OUT: square of all-ones = even powers
    stray_on_iss = 1'b1;
    run_op(10'h3FF, 10'h3FF, 19'h55555, 2, 1'b0, 3, 1'b1);
    stray_on_iss = 1'b0;

    // x^9 * x^9 = x^18 (top product bit), with 20 cycles of back-pressure
    run_op(10'h200, 10'h200, 19'h40000, 3, 1'b0, 20, 1'b0);

    // Reset during HI_WAIT, sub-multiplier answers late
    mul_lat = 6; starts = 0;
    in_valid = 1'b1; a_in = 10'h2C7; b_in = 10'h1B3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (dbg_state_o !== ST_HI_WAIT && guard < 100) begin @(posedge clk); #1; guard++; end
    check("reach_hi_wait", dbg_state_o, ST_HI_WAIT);
    hold_chk = 1'b0;
    rst_n = 1'b0;
    #2;
    check("async_rst_state", dbg_state_o, ST_IDLE);
    check("async_rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_count = '0;
    repeat (10) begin
      @(posedge clk); #1;
      check("late_done_state", dbg_state_o, ST_IDLE);
    end
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_op_count", op_count, '0);
    check("post_rst_in_ready", in_ready, 1'b1);
    hold_chk = 1'b1;

    // (x^5+1) * (x^9+...+1) = x^14+..+x^10 + x^4+..+1
    run_op(10'h021, 10'h3FF, 19'h07C1F, 1, 1'b0, 0, 1'b0);

    // Random operands, random latency, random back-pressure
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom_range(0, (1 << N) - 1));
      rb = N'($urandom_range(0, (1 << N) - 1));
      run_op(ra, rb, clmul(ra, rb), $urandom_range(1, 6), 1'b1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
